// File: rtl/note_pingpong_buffer_pkg.sv
// rtl/note_pingpong_buffer_pkg.sv - shared state encoding and lane-index width helper
package note_pingpong_buffer_pkg;

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;
  localparam logic [1:0] ST_CLEAR = 2'd3;

  // Lane index width; never below one bit so index ports stay legal.
  function automatic int lane_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/note_bank_ram.sv
// rtl/note_bank_ram.sv - single-clock lane RAM, one write port, one registered read port
module note_bank_ram #(
  parameter int DEPTH = 9,
  parameter int W     = 8,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Non-reset storage; read data only changes on a read so it holds between requests.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/note_pingpong_buffer.sv
// rtl/note_pingpong_buffer.sv - double-buffered per-lane note Y store with frame-sync swap
module note_pingpong_buffer
  import note_pingpong_buffer_pkg::*;
#(
  parameter int NUM_LANES     = 9,
  parameter int Y_W           = 8,
  parameter bit CLEAR_ON_SWAP = 1'b1,
  parameter int MISS_W        = 8
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           frame_sync,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [lane_w(NUM_LANES)-1:0]   wr_lane,
  input  logic [Y_W-1:0]                 wr_y,
  input  logic                           wr_done,
  input  logic                           rd_req,
  input  logic [lane_w(NUM_LANES)-1:0]   rd_lane,
  output logic                           rd_valid,
  output logic [Y_W-1:0]                 rd_y,
  output logic                           front_bank,
  output logic                           busy_clear,
  output logic [MISS_W-1:0]              missed_swaps
);

  localparam int              LW    = lane_w(NUM_LANES);
  localparam logic [LW:0]     LANES = (LW+1)'(NUM_LANES);
  localparam logic [LW-1:0]   LAST  = LW'(NUM_LANES - 1);

  logic [1:0]     state;
  logic [LW-1:0]  clr_cnt;
  logic           sel_q;
  logic           oob_q;
  logic           wr_in_range;
  logic           rd_in_range;
  logic [1:0]     we;
  logic [1:0]     re;
  logic [LW-1:0]  waddr;
  logic [Y_W-1:0] wdata;
  logic [Y_W-1:0] rdata0;
  logic [Y_W-1:0] rdata1;

  assign wr_in_range = {1'b0, wr_lane} < LANES;
  assign rd_in_range = {1'b0, rd_lane} < LANES;
  assign wr_ready    = (state == ST_FILL);
  assign busy_clear  = (state == ST_INIT) || (state == ST_CLEAR);

  // Write steering: INIT zeroes both banks, CLEAR zeroes the back bank, FILL writes the back bank.
  always_comb begin
    we    = 2'b00;
    waddr = clr_cnt;
    wdata = '0;
    case (state)
      ST_INIT:  we = 2'b11;
      ST_CLEAR: we = front_bank ? 2'b01 : 2'b10;
      ST_FILL: begin
        if (wr_valid && wr_in_range) begin
          we    = front_bank ? 2'b01 : 2'b10;
          waddr = wr_lane;
          wdata = wr_y;
        end
      end
      default: we = 2'b00;
    endcase
  end

  // The renderer only ever touches the front bank.
  assign re[0] = rd_req && rd_in_range && !front_bank;
  assign re[1] = rd_req && rd_in_range &&  front_bank;

  note_bank_ram #(.DEPTH(NUM_LANES), .W(Y_W), .AW(LW)) u_bank0 (
    .clk   (clk),
    .we    (we[0]),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re[0]),
    .raddr (rd_lane),
    .rdata (rdata0)
  );

  note_bank_ram #(.DEPTH(NUM_LANES), .W(Y_W), .AW(LW)) u_bank1 (
    .clk   (clk),
    .we    (we[1]),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re[1]),
    .raddr (rd_lane),
    .rdata (rdata1)
  );

  // Frame FSM: clear sweeps, fill, wait for frame sync to swap; counts unusable frame syncs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_INIT;
      clr_cnt      <= '0;
      front_bank   <= 1'b0;
      missed_swaps <= '0;
    end else begin
      case (state)
        ST_INIT, ST_CLEAR: begin
          if (clr_cnt == LAST) begin
            clr_cnt <= '0;
            state   <= ST_FILL;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_FILL: begin
          if (wr_done) state <= ST_READY;
        end
        ST_READY: begin
          if (frame_sync) begin
            front_bank <= ~front_bank;
            clr_cnt    <= '0;
            state      <= CLEAR_ON_SWAP ? ST_CLEAR : ST_FILL;
          end
        end
        default: state <= ST_INIT;
      endcase
      if (frame_sync && (state != ST_READY) && (missed_swaps != '1))
        missed_swaps <= missed_swaps + 1'b1;
    end
  end

  // Read bookkeeping: remember which bank and whether the lane was valid; hold between requests.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_valid <= 1'b0;
      sel_q    <= 1'b0;
      oob_q    <= 1'b1;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        sel_q <= front_bank;
        oob_q <= !rd_in_range;
      end
    end
  end

  assign rd_y = oob_q ? '0 : (sel_q ? rdata1 : rdata0);

endmodule

// File: tb/tb_note_pingpong_buffer.sv
// tb/tb_note_pingpong_buffer.sv - self-checking bench with behavioural model for note_pingpong_buffer
module tb_note_pingpong_buffer;

  localparam int N      = 9;
  localparam int YW     = 8;
  localparam int MW     = 8;
  localparam int LW     = 4;
  localparam int MAXMISS = (1 << MW) - 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          frame_sync = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [LW-1:0] wr_lane = '0;
  logic [YW-1:0] wr_y = '0;
  logic          wr_done = 1'b0;
  logic          rd_req = 1'b0;
  logic [LW-1:0] rd_lane = '0;
  logic          rd_valid;
  logic [YW-1:0] rd_y;
  logic          front_bank;
  logic          busy_clear;
  logic [MW-1:0] missed_swaps;

  int n_checks = 0;
  int n_fail   = 0;

  note_pingpong_buffer #(.NUM_LANES(N), .Y_W(YW), .CLEAR_ON_SWAP(1'b1), .MISS_W(MW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .frame_sync   (frame_sync),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_lane      (wr_lane),
    .wr_y         (wr_y),
    .wr_done      (wr_done),
    .rd_req       (rd_req),
    .rd_lane      (rd_lane),
    .rd_valid     (rd_valid),
    .rd_y         (rd_y),
    .front_bank   (front_bank),
    .busy_clear   (busy_clear),
    .missed_swaps (missed_swaps)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: modes 0=init sweep, 1=accepting writes, 2=frame complete, 3=clear sweep
  int m_bank [2][N];
  int m_front, m_mode, m_left, m_miss, m_rd_valid, m_rd_y;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_front = 0; m_mode = 0; m_left = N; m_miss = 0; m_rd_valid = 0; m_rd_y = 0;
      for (int b = 0; b < 2; b++) for (int k = 0; k < N; k++) m_bank[b][k] = 0;
    end else begin
      if (rd_req) begin
        m_rd_valid = 1;
        m_rd_y = (int'(rd_lane) < N) ? m_bank[m_front][rd_lane] : 0;
      end else begin
        m_rd_valid = 0;
      end
      if (frame_sync && m_mode != 2 && m_miss < MAXMISS) m_miss++;
      case (m_mode)
        0, 3: begin
          m_left--;
          if (m_left == 0) m_mode = 1;
        end
        1: begin
          if (wr_valid && int'(wr_lane) < N) m_bank[1 - m_front][wr_lane] = int'(wr_y);
          if (wr_done) m_mode = 2;
        end
        default: begin
          if (frame_sync) begin
            m_front = 1 - m_front;
            for (int k = 0; k < N; k++) m_bank[1 - m_front][k] = 0;
            m_mode = 3;
            m_left = N;
          end
        end
      endcase
    end
  end

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (resetn) begin
      check("cyc_rd_valid", 32'(rd_valid), 32'(m_rd_valid));
      check("cyc_rd_y", 32'(rd_y), 32'(m_rd_y));
      check("cyc_front_bank", 32'(front_bank), 32'(m_front));
      check("cyc_busy_clear", 32'(busy_clear), 32'((m_mode == 0) || (m_mode == 3)));
      check("cyc_wr_ready", 32'(wr_ready), 32'(m_mode == 1));
      check("cyc_missed", 32'(missed_swaps), 32'(m_miss));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int lane);
    rd_req = 1'b1;
    rd_lane = LW'(lane);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic do_write(input int lane, input int y);
    wr_valid = 1'b1;
    wr_lane = LW'(lane);
    wr_y = YW'(y);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_sync();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
  endtask

  // Counts cycles until busy_clear drops; bounded so a stuck clear cannot hang the run
  task automatic busy_len(input string name, input int exp);
    int n = 0;
    while (busy_clear && n < 50) begin
      tick();
      n++;
    end
    check(name, 32'(n), 32'(exp));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_front", 32'(front_bank), 32'd0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_rd_y", 32'(rd_y), 32'd0);
    check("reset_missed", 32'(missed_swaps), 32'd0);
    check("reset_wr_ready", 32'(wr_ready), 32'd0);
    check("reset_busy", 32'(busy_clear), 32'd1);
    resetn = 1'b1;
    busy_len("init_len", 9);
    check("init_wr_ready", 32'(wr_ready), 32'd1);

    for (int k = 0; k < N; k++) begin
      do_read(k);
      check("init_read_valid", 32'(rd_valid), 32'd1);
      check("init_read_zero", 32'(rd_y), 32'd0);
    end

    for (int k = 0; k < N - 1; k++) do_write(k, (k + 1) * 10);
    do_write(9, 8'h55);
    wr_done = 1'b1;
    do_write(8, 90);
    wr_done = 1'b0;
    check("ready_wr_ready", 32'(wr_ready), 32'd0);
    do_write(2, 8'hAA);

    frame_sync = 1'b1;
    do_read(3);
    frame_sync = 1'b0;
    check("swap_front", 32'(front_bank), 32'd1);
    check("swap_edge_read_old_bank", 32'(rd_y), 32'd0);
    busy_len("clear_len", 9);
    do_read(3);
    check("lane3_after_swap", 32'(rd_y), 32'd40);
    do_read(2);
    check("lane2_ready_write_ignored", 32'(rd_y), 32'd30);
    do_read(8);
    check("lane8_with_done", 32'(rd_y), 32'd90);
    do_read(9);
    check("oob_read_valid", 32'(rd_valid), 32'd1);
    check("oob_read_zero", 32'(rd_y), 32'd0);
    tick();
    check("rd_valid_drops", 32'(rd_valid), 32'd0);

    pulse_sync();
    check("missed_one", 32'(missed_swaps), 32'd1);
    check("missed_front_kept", 32'(front_bank), 32'd1);

    do_write(0, 7);
    wr_done = 1'b1;
    frame_sync = 1'b1;
    tick();
    wr_done = 1'b0;
    frame_sync = 1'b0;
    check("simul_missed", 32'(missed_swaps), 32'd2);
    check("simul_no_swap", 32'(front_bank), 32'd1);
    check("simul_ready", 32'(wr_ready), 32'd0);
    pulse_sync();
    check("simul_then_swap", 32'(front_bank), 32'd0);
    busy_len("clear_len2", 9);
    do_read(0);
    check("lane0_new_frame", 32'(rd_y), 32'd7);
    do_read(3);
    check("lane3_cleared", 32'(rd_y), 32'd0);

    for (int i = 0; i < 300; i++) pulse_sync();
    check("missed_saturated", 32'(missed_swaps), 32'd255);

    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    pulse_sync();
    check("pre_reset_front", 32'(front_bank), 32'd1);
    repeat (4) tick();
    #1;
    resetn = 1'b0;
    #1;
    check("async_front", 32'(front_bank), 32'd0);
    check("async_missed", 32'(missed_swaps), 32'd0);
    check("async_rd_valid", 32'(rd_valid), 32'd0);
    check("async_rd_y", 32'(rd_y), 32'd0);
    check("async_busy", 32'(busy_clear), 32'd1);
    check("async_wr_ready", 32'(wr_ready), 32'd0);
    tick();
    resetn = 1'b1;
    busy_len("reinit_len", 9);
    do_read(4);
    check("reinit_read_zero", 32'(rd_y), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/note_pingpong_buffer.md
Name: note_pingpong_buffer

Overview:
Parametrised double-buffered store of per-lane note Y positions for the rhythm-game display path. An update engine writes one complete frame of lane positions into the back bank while the VGA renderer reads the front bank. The banks swap only on a frame-sync pulse, and only once the back frame is complete. This generalises the single-lane, fixed 8-bit ping-pong scheme to N lanes, adds frame-complete gating, optional clear-on-swap, and missed-swap accounting.

Parameters:
NUM_LANES, 9, number of note lanes (entries per bank), >=2
Y_W, 8, width of one Y position
CLEAR_ON_SWAP, 1, 1 = zero the new back bank after every swap; 0 = keep stale contents
MISS_W, 8, width of saturating missed-swap counter

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
frame_sync  in  1  one-cycle pulse at VGA vertical blank (swap opportunity)
wr_valid  in  1  write request
wr_ready  out  1  writer may write this cycle
wr_lane  in  $clog2(NUM_LANES)  lane index to write
wr_y  in  Y_W  Y position to write
wr_done  in  1  pulse: back frame complete
rd_req  in  1  read request from renderer
rd_lane  in  $clog2(NUM_LANES)  lane index to read
rd_valid  out  1  rd_y valid (1 cycle after rd_req)
rd_y  out  Y_W  Y position from front bank
front_bank  out  1  index of bank currently displayed
busy_clear  out  1  clear sequence in progress
missed_swaps  out  MISS_W  count of frame_sync pulses with no completed frame, saturating

Behaviour:
- Reset (async, resetn=0): front_bank=0, rd_valid=0, rd_y=0, missed_swaps=0, state=INIT, clear counter=0, wr_ready=0.
- States: INIT, FILL, READY, CLEAR.
- INIT: writes 0 to lane k of both banks on cycle k; lasts NUM_LANES cycles, then goes to FILL. busy_clear=1.
- FILL: wr_ready=1. A write when wr_valid&&wr_ready stores wr_y into the back bank at wr_lane. wr_lane>=NUM_LANES: write dropped. wr_done moves to READY; a write in the same cycle as wr_done is still accepted.
- READY: wr_ready=0; writes are ignored. On frame_sync, front_bank toggles that same edge, then state goes to CLEAR if CLEAR_ON_SWAP=1, else to FILL.
- CLEAR: zeroes the new back bank one lane per cycle for NUM_LANES cycles, then goes to FILL. busy_clear=1; wr_ready=0.
- frame_sync in INIT, FILL or CLEAR: no swap; missed_swaps increments, saturating at all-ones.
- wr_done and frame_sync in the same cycle in FILL: wr_done is recorded (goes to READY); no swap; missed_swaps increments. The swap happens at the next frame_sync.
- wr_done outside FILL: ignored.
- Read path: rd_req at cycle t returns front-bank[rd_lane] with rd_valid=1 at t+1. Otherwise rd_valid=0 and rd_y holds its last value.
  - Out-of-range rd_lane: rd_y=0, rd_valid=1.
  - A read whose rd_req coincides with a swap edge returns data from the pre-swap front bank.
- The reader never accesses the back bank, so read/write collisions are impossible by construction.
- Memories are non-reset arrays. Only INIT/CLEAR define their contents.

Decomposition:
- Shared package: state encoding (INIT/FILL/READY/CLEAR), and a lane-index width function clog2 of NUM_LANES.
- One sub-module: note_bank_ram. Single-clock RAM with NUM_LANES x Y_W entries, 1 write port, 1 registered read port; instantiated twice.
- The bank-select mux and FSM stay in the top module.

Test Plan:
- Reset/INIT (NUM_LANES=9): deassert resetn, wait 9 cycles -> busy_clear falls, wr_ready=1. Reading any lane returns 0 with rd_valid one cycle later.
- Fill and swap: write lane0=8'd10 ... lane8=8'd90, pulse wr_done, then frame_sync -> front_bank 0->1. Read lane3 -> 8'd40 at t+1. CLEAR_ON_SWAP=1: busy_clear high for 9 cycles.
- Missed frame: frame_sync during FILL with no wr_done -> front_bank unchanged, missed_swaps=1. Repeat 300 times with MISS_W=8 -> missed_swaps saturates at 255.
- Simultaneous events: wr_done and frame_sync in the same FILL cycle -> no swap, missed_swaps +1, state READY. Next frame_sync -> swap.
- Write gating: wr_valid in READY with wr_y=8'hAA -> ignored; the value does not appear after the swap. Out-of-range wr_lane=9 -> no bank change.
- Async reset mid-CLEAR: resetn low on clear cycle 4 -> outputs reset immediately, front_bank=0, missed_swaps=0, INIT restarts from lane 0.
